// File: rtl/lamp_seq_monitor_if.sv
// lamp_seq_monitor_if: lamp bus, clear strobe and monitor result signals
interface lamp_seq_monitor_if #(
  parameter int WIDTH = 4,
  parameter int POS_W = 3,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] lamp;
  logic             clr;
  logic [POS_W-1:0] pos;
  logic             locked;
  logic [CNT_W-1:0] lap_cnt;
  logic             err_onehot;
  logic             err_skip;
  logic             err_stuck;
  logic             err_any;
  modport master (
    output lamp, clr,
    input  pos, locked, lap_cnt, err_onehot, err_skip, err_stuck, err_any
  );
  modport slave (
    input  lamp, clr,
    output pos, locked, lap_cnt, err_onehot, err_skip, err_stuck, err_any
  );
endinterface

// File: rtl/lamp_seq_monitor.sv
// lamp_seq_monitor: locks onto a one-hot running light, counts laps, flags sticky errors.
// Define LAMP_MON_LAPCNT_EN to build the lap counter; otherwise lap_cnt is tied to 0.
module lamp_seq_monitor #(
  parameter int WIDTH     = 4,
  parameter int POS_W     = 3,
  parameter int CNT_W     = 8,
  parameter int STUCK_MAX = 1
) (
  input logic clk,
  input logic rset,
  lamp_seq_monitor_if.slave bus
);
  typedef enum logic [1:0] {DARK, ACQUIRE, LOCKED} state_t;
  localparam logic [POS_W-1:0] PMAX = POS_W'(WIDTH);
  localparam logic [POS_W-1:0] PONE = POS_W'(1);
  localparam logic [8:0]       SMAX = 9'(STUCK_MAX);
  state_t           state, state_n;
  logic [POS_W-1:0] pos_q, dp;
  logic [8:0]       hold, hold_n, hold_inc;
  logic             multi, lap_inc, e_oh, e_sk, e_st;
  logic             oh_q, sk_q, st_q, any_q, oh_n, sk_n, st_n;
  always_comb begin
    dp = '0;
    for (int i = 0; i < WIDTH; i++) if (bus.lamp[i]) dp = POS_W'(i + 1);
    multi = |(bus.lamp & (bus.lamp - 1'b1));
    if (multi) dp = '0;
    state_n  = state;
    hold_n   = hold;
    hold_inc = (hold == '1) ? hold : hold + 1'b1;
    lap_inc  = 1'b0;
    e_oh     = multi;
    e_sk     = 1'b0;
    e_st     = 1'b0;
    if (state == LOCKED) begin
      if (multi) state_n = ACQUIRE;
      else if (dp == '0) state_n = DARK;
      else if (pos_q != PMAX && dp == pos_q + 1'b1) hold_n = 9'd1;
      else if (pos_q == PMAX && dp == PONE) begin
        hold_n  = 9'd1;
        lap_inc = 1'b1;
      end else if (dp == pos_q) begin
        hold_n = hold_inc;
        if (hold_inc > SMAX) begin
          e_st    = 1'b1;
          state_n = ACQUIRE;
        end
      end else begin
        e_sk    = 1'b1;
        state_n = ACQUIRE;
      end
    end else if (multi) state_n = ACQUIRE;
    else if (dp == PONE) begin
      state_n = LOCKED;
      hold_n  = 9'd1;
    end else state_n = (dp == '0) ? DARK : ACQUIRE;
  end
  // clr wipes the old value first, so an event in the same cycle still lands
  always_comb begin
    oh_n = (oh_q & ~bus.clr) | e_oh;
    sk_n = (sk_q & ~bus.clr) | e_sk;
    st_n = (st_q & ~bus.clr) | e_st;
  end
  always_ff @(posedge clk or negedge rset) begin
    if (!rset) begin
      state <= DARK;
      pos_q <= '0;
      hold  <= '0;
      oh_q  <= 1'b0;
      sk_q  <= 1'b0;
      st_q  <= 1'b0;
      any_q <= 1'b0;
    end else begin
      state <= state_n;
      pos_q <= dp;
      hold  <= hold_n;
      oh_q  <= oh_n;
      sk_q  <= sk_n;
      st_q  <= st_n;
      any_q <= oh_n | sk_n | st_n;
    end
  end
`ifdef LAMP_MON_LAPCNT_EN
  logic [CNT_W-1:0] lap_q;
  always_ff @(posedge clk or negedge rset) begin
    if (!rset) lap_q <= '0;
    else lap_q <= (bus.clr ? '0 : lap_q) + (lap_inc ? CNT_W'(1) : CNT_W'(0));
  end
  assign bus.lap_cnt = lap_q;
`else
  logic unused_lap;
  assign unused_lap  = lap_inc;
  assign bus.lap_cnt = '0;
`endif
  always_comb begin
    bus.pos        = pos_q;
    bus.locked     = (state == LOCKED);
    bus.err_onehot = oh_q;
    bus.err_skip   = sk_q;
    bus.err_stuck  = st_q;
    bus.err_any    = any_q;
  end
endmodule

// File: tb/tb_lamp_seq_monitor.sv
// tb_lamp_seq_monitor: directed scenarios for lamp_seq_monitor with hand-computed expectations
module tb_lamp_seq_monitor;
`ifdef LAMP_MON_LAPCNT_EN
  localparam int LAP_EN = 1;
`else
  localparam int LAP_EN = 0;
`endif
  logic clk = 1'b0;
  logic rset;
  int   checks = 0;
  int   failures = 0;
  lamp_seq_monitor_if #(.WIDTH(4), .POS_W(3), .CNT_W(8)) bus ();
  lamp_seq_monitor #(.WIDTH(4), .POS_W(3), .CNT_W(8), .STUCK_MAX(1)) dut (
    .clk (clk),
    .rset(rset),
    .bus (bus)
  );
  always #5 clk = ~clk;
  task automatic step(input logic [3:0] l, input logic c);
    @(negedge clk);
    bus.lamp = l;
    bus.clr  = c;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rset = 1'b0;
    bus.lamp = 4'b0;
    bus.clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.pos !== 3'd0) begin failures++; $display("FAIL rst_pos got=%0d exp=0", bus.pos); end
    checks++; if (bus.locked !== 1'b0) begin failures++; $display("FAIL rst_locked got=%b exp=0", bus.locked); end
    checks++; if (bus.lap_cnt !== 8'd0) begin failures++; $display("FAIL rst_lap got=%0d exp=0", bus.lap_cnt); end
    checks++; if ({bus.err_onehot, bus.err_skip, bus.err_stuck, bus.err_any} !== 4'b0) begin
      failures++; $display("FAIL rst_errs got=%b exp=0000", {bus.err_onehot, bus.err_skip, bus.err_stuck, bus.err_any});
    end
    @(negedge clk);
    rset = 1'b1;
  endtask
  task automatic test_rotation;
    logic [3:0] lamps [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [2:0] exp_p [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
    logic       exp_l [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      step(lamps[i], 1'b0);
      checks++; if (bus.pos !== exp_p[i]) begin failures++; $display("FAIL rot_pos[%0d] got=%0d exp=%0d", i, bus.pos, exp_p[i]); end
      checks++; if (bus.locked !== exp_l[i]) begin failures++; $display("FAIL rot_locked[%0d] got=%b exp=%b", i, bus.locked, exp_l[i]); end
      checks++; if (bus.err_any !== 1'b0) begin failures++; $display("FAIL rot_any[%0d] got=%b exp=0", i, bus.err_any); end
    end
    checks++; if (bus.lap_cnt !== 8'(LAP_EN)) begin failures++; $display("FAIL rot_lap got=%0d exp=%0d", bus.lap_cnt, LAP_EN); end
  endtask
  task automatic test_skip;
    step(4'b0010, 1'b0);
    step(4'b1000, 1'b0);
    checks++; if (bus.err_skip !== 1'b1) begin failures++; $display("FAIL skip_flag got=%b exp=1", bus.err_skip); end
    checks++; if (bus.err_any !== 1'b1) begin failures++; $display("FAIL skip_any got=%b exp=1", bus.err_any); end
    checks++; if (bus.locked !== 1'b0) begin failures++; $display("FAIL skip_locked got=%b exp=0", bus.locked); end
    step(4'b0001, 1'b0);
    checks++; if (bus.locked !== 1'b1) begin failures++; $display("FAIL skip_relock got=%b exp=1", bus.locked); end
    checks++; if (bus.err_skip !== 1'b1) begin failures++; $display("FAIL skip_sticky got=%b exp=1", bus.err_skip); end
    step(4'b0010, 1'b1);
    checks++; if ({bus.err_skip, bus.err_any} !== 2'b00) begin failures++; $display("FAIL skip_clr got=%b exp=00", {bus.err_skip, bus.err_any}); end
    checks++; if (bus.lap_cnt !== 8'd0) begin failures++; $display("FAIL skip_clr_lap got=%0d exp=0", bus.lap_cnt); end
    checks++; if (bus.locked !== 1'b1) begin failures++; $display("FAIL skip_clr_locked got=%b exp=1", bus.locked); end
    step(4'b1000, 1'b1);
    checks++; if ({bus.err_skip, bus.err_any} !== 2'b11) begin failures++; $display("FAIL skip_clr_event got=%b exp=11", {bus.err_skip, bus.err_any}); end
    step(4'b0000, 1'b1);
    checks++; if (bus.err_any !== 1'b0) begin failures++; $display("FAIL skip_clr2 got=%b exp=0", bus.err_any); end
  endtask
  task automatic test_stuck;
    step(4'b0001, 1'b0);
    step(4'b0010, 1'b0);
    step(4'b0100, 1'b0);
    checks++; if ({bus.locked, bus.err_stuck} !== 2'b10) begin failures++; $display("FAIL stuck_pre got=%b exp=10", {bus.locked, bus.err_stuck}); end
    step(4'b0100, 1'b0);
    checks++; if (bus.err_stuck !== 1'b1) begin failures++; $display("FAIL stuck_flag got=%b exp=1", bus.err_stuck); end
    checks++; if (bus.locked !== 1'b0) begin failures++; $display("FAIL stuck_locked got=%b exp=0", bus.locked); end
    checks++; if ({bus.err_skip, bus.err_onehot, bus.err_any} !== 3'b001) begin
      failures++; $display("FAIL stuck_others got=%b exp=001", {bus.err_skip, bus.err_onehot, bus.err_any});
    end
    step(4'b0000, 1'b1);
  endtask
  task automatic test_onehot;
    step(4'b0110, 1'b0);
    checks++; if (bus.err_onehot !== 1'b1) begin failures++; $display("FAIL oh_flag got=%b exp=1", bus.err_onehot); end
    checks++; if (bus.pos !== 3'd0) begin failures++; $display("FAIL oh_pos got=%0d exp=0", bus.pos); end
    checks++; if ({bus.locked, bus.err_any} !== 2'b01) begin failures++; $display("FAIL oh_state got=%b exp=01", {bus.locked, bus.err_any}); end
    step(4'b0010, 1'b0);
    checks++; if ({bus.locked, bus.pos} !== 4'b0010) begin failures++; $display("FAIL oh_acq got=%b exp=0010", {bus.locked, bus.pos}); end
    step(4'b0001, 1'b0);
    checks++; if ({bus.locked, bus.err_onehot} !== 2'b11) begin failures++; $display("FAIL oh_relock got=%b exp=11", {bus.locked, bus.err_onehot}); end
    step(4'b0000, 1'b1);
  endtask
  task automatic test_lap_clr;
    step(4'b0001, 1'b0);
    step(4'b0010, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b1000, 1'b0);
    checks++; if ({bus.locked, bus.pos} !== 4'b1100) begin failures++; $display("FAIL lap_at4 got=%b exp=1100", {bus.locked, bus.pos}); end
    checks++; if (bus.lap_cnt !== 8'd0) begin failures++; $display("FAIL lap_pre got=%0d exp=0", bus.lap_cnt); end
    step(4'b0001, 1'b1);
    checks++; if (bus.lap_cnt !== 8'(LAP_EN)) begin failures++; $display("FAIL lap_clr_inc got=%0d exp=%0d", bus.lap_cnt, LAP_EN); end
    checks++; if ({bus.locked, bus.err_any} !== 2'b10) begin failures++; $display("FAIL lap_clr_state got=%b exp=10", {bus.locked, bus.err_any}); end
    step(4'b0000, 1'b0);
    checks++; if ({bus.locked, bus.pos, bus.err_any} !== 5'b00000) begin
      failures++; $display("FAIL lap_dark got=%b exp=00000", {bus.locked, bus.pos, bus.err_any});
    end
  endtask
  task automatic test_async_reset;
    step(4'b0001, 1'b0);
    step(4'b0010, 1'b0);
    step(4'b0010, 1'b0);
    #2 rset = 1'b0;
    #1;
    checks++; if ({bus.pos, bus.locked} !== 4'b0000) begin failures++; $display("FAIL ar_pos_locked got=%b exp=0000", {bus.pos, bus.locked}); end
    checks++; if (bus.lap_cnt !== 8'd0) begin failures++; $display("FAIL ar_lap got=%0d exp=0", bus.lap_cnt); end
    checks++; if ({bus.err_onehot, bus.err_skip, bus.err_stuck, bus.err_any} !== 4'b0) begin
      failures++; $display("FAIL ar_errs got=%b exp=0000", {bus.err_onehot, bus.err_skip, bus.err_stuck, bus.err_any});
    end
    #2 rset = 1'b1;
    step(4'b0010, 1'b0);
    checks++; if ({bus.locked, bus.pos} !== 4'b0010) begin failures++; $display("FAIL ar_acq got=%b exp=0010", {bus.locked, bus.pos}); end
    step(4'b0001, 1'b0);
    checks++; if (bus.locked !== 1'b1) begin failures++; $display("FAIL ar_relock got=%b exp=1", bus.locked); end
  endtask
  initial begin
    test_reset();
    test_rotation();
    test_skip();
    test_stuck();
    test_onehot();
    test_lap_clr();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
